aes_pad_adder: RTL
==================

// Module: aes_pad_adder
// PURPOSE
// - Upstream data stage of the AES engine: accepts a message as a stream of REG_SIZE-bit words.
// - Message length (words) and msg_start come from register_controller (msg_words_out, msg_start).
// - Groups words into 128-bit AES blocks and appends word-granular PKCS#7-style padding.
// - Reports the accepted-word count back to register_controller as msg_words_in_adder.
// PARAMETERS
// - REG_SIZE          32  data word width; must be 32 (4 words per 128-bit block)
// - WORD_COUNTER_SIZE 16  width of message-length and word counters
// - WORDS_PER_BLOCK   4   words per AES block (fixed)
// PORTS
// - clk                 in   1                  clock; single clock domain
// - rst_n               in   1                  synchronous active-low reset
// - msg_start           in   1                  1-cycle pulse: start new message
// - msg_words_out       in   WORD_COUNTER_SIZE  message length L in words, sampled on accepted msg_start
// - msg_words_in_adder  out  WORD_COUNTER_SIZE  data words accepted in current/last message
// - in_valid            in   1                  input word valid
// - in_data             in   REG_SIZE           input word
// - in_ready            out  1                  stage can take a word
// - out_valid           out  1                  128-bit block valid
// - out_data            out  REG_SIZE*4        block; first word in [127:96], last word in [31:0]
// - out_last            out  1                  block is the final, padded block of the message
// - out_ready           in   1                  downstream accepts block
// - busy                out  1                  state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; in_ready, out_valid, out_last, busy = 0; out_data = 0; msg_words_in_adder = 0; internal counters = 0.
// - Handshakes: word transfer when in_valid & in_ready; block transfer when out_valid & out_ready.
// - out_valid/out_data/out_last are held stable until accepted.
// - FSM states:
//   - IDLE: msg_start=1 latches L=msg_words_out, clears msg_words_in_adder and slot index -> FILL (L>0) or PAD (L=0).
//   - FILL: in_ready=1. Each transfer writes word into slot k, k++, msg_words_in_adder++.
//     - k reaches 4 -> OUT.
//     - All L words taken with k in 1..3 -> PAD.
//   - PAD: 1 cycle. Fills slots k..3 with P = 4-k, zero-extended to 32 bits; sets out_last -> OUT.
//   - OUT: out_valid=1; in_ready=0. On block transfer:
//     - out_last=1 -> IDLE.
//     - All L words taken (L mod 4 == 0) -> PAD with k=0, giving a full block of four words = 4.
//     - Otherwise -> FILL with k=0.
// - Padding rule: P = 4 - (L mod 4), range 1..4; every message emits ceil((L+1)/4) blocks; exactly one block has out_last.
// - Latency:
//   - 4th word of a block accepted at cycle t -> out_valid at t+1.
//   - Final data word of an unaligned message at t -> PAD at t+1 -> out_valid at t+2.
// - msg_start outside IDLE is ignored; no effect on state or counters.
// - L = 2^WORD_COUNTER_SIZE-1 is legal; counters never wrap within a message.
// - msg_words_in_adder holds its final value (L) after completion until the next accepted msg_start.
// - Reset mid-message: the partial block is discarded; all outputs return to reset values the next cycle.
// - out_ready asserted while out_valid=0 has no effect.
// CONFIGURATION
// - AES_PAD_ADDER_ABORT_EN defined: adds input msg_abort (1 bit).
//   - msg_abort=1 in any state -> IDLE next cycle; out_valid/in_ready drop; buffered words discarded.
//   - msg_words_in_adder keeps its count.
//   - msg_abort takes priority over a simultaneous msg_start or handshake.
// - AES_PAD_ADDER_ABORT_EN undefined: no msg_abort port; a message ends only on its out_last transfer or on reset.
// TESTING
// - L=4, words 0x11..0x44, out_ready=1 -> block 0x11_22_33_44 (out_last=0), then block {4x 0x00000004} (out_last=1); msg_words_in_adder=4.
// - L=5, words A..E -> block {A,B,C,D}, then block {E,3,3,3} (out_last=1) at t+2 after E accepted.
// - L=0 -> single block {4,4,4,4} with out_last=1; in_ready never asserted.
// - L=3, out_ready held 0 for 10 cycles -> out_data/out_valid stable; in_ready=0; transfer on release; then IDLE.
// - msg_start pulsed during FILL with msg_words_out=9 -> ignored; message completes with the original L; rst_n=0 mid-FILL -> reset values next cycle.
// - AES_PAD_ADDER_ABORT_EN: abort after 2 of L=8 words -> IDLE, no out_valid, msg_words_in_adder=2; a new msg_start is then accepted.

Source files
------------

// File: rtl/aes_pad_adder.sv
// Purpose : packs 32-bit message words into 128-bit AES blocks and appends word-granular PKCS#7-style padding.
// Latency : 4th word of a block at t -> out_valid at t+1; final word of an unaligned message at t -> out_valid at t+2.
// Backpressure: in_ready is low while a block is waiting; out_valid/out_data/out_last hold until out_ready.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   msg_start, msg_words_out          start pulse and message length L (words), taken only in IDLE
//   msg_words_in_adder                data words accepted in the current/last message
//   in_valid, in_data, in_ready       word input handshake
//   out_valid, out_data, out_last,
//   out_ready                         block output handshake; first word in [127:96]
//   busy                              FSM not idle
//   msg_abort                         only with AES_PAD_ADDER_ABORT_EN defined: drop the message, return to IDLE
//
// Build option: define AES_PAD_ADDER_ABORT_EN to add the msg_abort input.
module aes_pad_adder #(
    parameter int REG_SIZE          = 32,
    parameter int WORD_COUNTER_SIZE = 16,
    parameter int WORDS_PER_BLOCK   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
`ifdef AES_PAD_ADDER_ABORT_EN
    input  logic                                  msg_abort,
`endif
    input  logic                                  msg_start,
    input  logic [WORD_COUNTER_SIZE-1:0]          msg_words_out,
    output logic [WORD_COUNTER_SIZE-1:0]          msg_words_in_adder,
    input  logic                                  in_valid,
    input  logic [REG_SIZE-1:0]                   in_data,
    output logic                                  in_ready,
    output logic                                  out_valid,
    output logic [REG_SIZE*WORDS_PER_BLOCK-1:0]   out_data,
    output logic                                  out_last,
    input  logic                                  out_ready,
    output logic                                  busy
);

    localparam int SLOT_W = $clog2(WORDS_PER_BLOCK) + 1;
    localparam logic [SLOT_W-1:0]            LAST_SLOT = SLOT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [SLOT_W-1:0]            BLK_WORDS = SLOT_W'(WORDS_PER_BLOCK);
    localparam logic [WORD_COUNTER_SIZE-1:0] CNT_ONE   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [WORD_COUNTER_SIZE-1:0]   msg_len;
    logic [SLOT_W-1:0]              slot;
    logic                           abort;
    logic                           word_fire;
    logic                           blk_fire;
    logic                           last_word;
    logic                           all_taken;
    logic [REG_SIZE-1:0]            pad_word;

`ifdef AES_PAD_ADDER_ABORT_EN
    assign abort = msg_abort;
`else
    assign abort = 1'b0;
`endif

    assign in_ready  = (state == FILL);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    assign word_fire = in_valid & in_ready;
    assign blk_fire  = out_valid & out_ready;

    // last_word is only consulted in FILL, where L > 0, so L-1 cannot underflow.
    assign last_word = (msg_words_in_adder == msg_len - CNT_ONE);
    assign all_taken = (msg_words_in_adder == msg_len);

    // Pad value equals the number of empty slots left in the block (1..4).
    assign pad_word  = REG_SIZE'(BLK_WORDS - slot);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (msg_start) begin
                    state_nxt = (msg_words_out == '0) ? PAD : FILL;
                end
            end
            FILL: begin
                if (word_fire) begin
                    if (slot == LAST_SLOT) begin
                        state_nxt = OUT;
                    end else if (last_word) begin
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (blk_fire) begin
                    if (out_last) begin
                        state_nxt = IDLE;
                    end else if (all_taken) begin
                        // Aligned message: one extra block made entirely of padding.
                        state_nxt = PAD;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_len            <= '0;
            msg_words_in_adder <= '0;
            slot               <= '0;
            out_data           <= '0;
            out_last           <= 1'b0;
        end else if (abort) begin
            // Word count is deliberately kept so software can see how far the message got.
            slot     <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (msg_start) begin
                        msg_len            <= msg_words_out;
                        msg_words_in_adder <= '0;
                        slot               <= '0;
                        out_last           <= 1'b0;
                    end
                end
                FILL: begin
                    if (word_fire) begin
                        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                            if (SLOT_W'(i) == slot) begin
                                out_data[(WORDS_PER_BLOCK-1-i)*REG_SIZE +: REG_SIZE] <= in_data;
                            end
                        end
                        slot               <= slot + SLOT_W'(1);
                        msg_words_in_adder <= msg_words_in_adder + CNT_ONE;
                    end
                end
                PAD: begin
                    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                        if (SLOT_W'(i) >= slot) begin
                            out_data[(WORDS_PER_BLOCK-1-i)*REG_SIZE +: REG_SIZE] <= pad_word;
                        end
                    end
                    out_last <= 1'b1;
                end
                OUT: begin
                    if (blk_fire) begin
                        slot     <= '0;
                        out_last <= 1'b0;
                    end
                end
                default: begin
                    slot <= '0;
                end
            endcase
        end
    end

endmodule
